mastermind_game_sequencer: RTL and testbench

//   Top-level game sequencer for Mastermind. Sequences digit entry into the code/guess

---
 rtl/mastermind_game_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mastermind_game_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_game_sequencer.sv
// mastermind_game_sequencer
//   Top-level game sequencer for Mastermind.
//   - Steers digit entry into the code and guess registers.
//   - Starts the peg scorer and latches the red/white result.
//   - Counts scored guesses and declares a win or a loss.
//   Every output is registered.
//
// Ports
//   clk, resetn              clock; synchronous active-low reset
//   load_btn                 load key (active-high level)
//   new_game                 restart the game (active-high level)
//   sel_digit                digit slot for code_we / guess_we
//   code_we, guess_we        1-cycle write strobes
//   score_start              1-cycle scorer start pulse
//   score_done               scorer result valid; red_in and white_in are sampled here
//   red_in, white_in         scorer peg counts
//   red_out, white_out       latched result of the last scored guess
//   guess_cnt                number of guesses scored this game
//   win, lose                high while in WIN or LOSE
//   state_dbg                current state encoding
module mastermind_game_sequencer #(
  parameter int DIGITS      = 4,
  parameter int IDX_W       = 2,
  parameter int PEG_W       = 3,
  parameter int MAX_GUESSES = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_btn,
  input  logic             new_game,
  output logic [IDX_W-1:0] sel_digit,
  output logic             code_we,
  output logic             guess_we,
  output logic             score_start,
  input  logic             score_done,
  input  logic [PEG_W-1:0] red_in,
  input  logic [PEG_W-1:0] white_in,
  output logic [PEG_W-1:0] red_out,
  output logic [PEG_W-1:0] white_out,
  output logic [CNT_W-1:0] guess_cnt,
  output logic             win,
  output logic             lose,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_CODE  = 3'd0,
    S_GUESS = 3'd1,
    S_SCORE = 3'd2,
    S_WAIT  = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx, sel_nx;
  logic             load_prev;
  logic             press, last_digit;
  logic             code_we_nx, guess_we_nx, score_start_nx, win_nx, lose_nx;
  logic [PEG_W-1:0] red_nx, white_nx;
  logic [CNT_W-1:0] cnt_nx, cnt_inc;

  // Rising edge of the key: a held key yields exactly one press.
  assign press      = load_btn & ~load_prev;
  assign last_digit = (idx == IDX_W'(DIGITS - 1));
  assign cnt_inc    = guess_cnt + CNT_W'(1);
  assign state_dbg  = state;

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    sel_nx      = sel_digit;
    code_we_nx  = 1'b0;
    guess_we_nx = 1'b0;
    red_nx      = red_out;
    white_nx    = white_out;
    cnt_nx      = guess_cnt;

    if (new_game) begin
      // A restart wins over a press or a score result in the same cycle.
      state_nx = S_CODE;
      idx_nx   = '0;
      cnt_nx   = '0;
      red_nx   = '0;
      white_nx = '0;
    end else begin
      unique case (state)
        S_CODE: if (press) begin
          code_we_nx = 1'b1;
          sel_nx     = idx;
          if (last_digit) begin
            idx_nx   = '0;
            state_nx = S_GUESS;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
        S_GUESS: if (press) begin
          guess_we_nx = 1'b1;
          sel_nx      = idx;
          if (last_digit) begin
            idx_nx   = '0;
            state_nx = S_SCORE;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
        S_SCORE: state_nx = S_WAIT;
        S_WAIT: if (score_done) begin
          red_nx   = red_in;
          white_nx = white_in;
          cnt_nx   = cnt_inc;
          if (red_in == PEG_W'(DIGITS))           state_nx = S_WIN;
          else if (cnt_inc == CNT_W'(MAX_GUESSES)) state_nx = S_LOSE;
          else                                     state_nx = S_GUESS;
        end
        S_WIN:   state_nx = S_WIN;
        S_LOSE:  state_nx = S_LOSE;
        default: state_nx = S_CODE;
      endcase
    end

    // Registered decodes of the next state. score_start is high for the single
    // cycle spent in SCORE, so it cannot be re-issued during SCORE_WAIT.
    score_start_nx = (state_nx == S_SCORE);
    win_nx         = (state_nx == S_WIN);
    lose_nx        = (state_nx == S_LOSE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_CODE;
      idx         <= '0;
      load_prev   <= 1'b1;   // a key held through reset is not captured
      sel_digit   <= '0;
      code_we     <= 1'b0;
      guess_we    <= 1'b0;
      score_start <= 1'b0;
      red_out     <= '0;
      white_out   <= '0;
      guess_cnt   <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      load_prev   <= load_btn;
      sel_digit   <= sel_nx;
      code_we     <= code_we_nx;
      guess_we    <= guess_we_nx;
      score_start <= score_start_nx;
      red_out     <= red_nx;
      white_out   <= white_nx;
      guess_cnt   <= cnt_nx;
      win         <= win_nx;
      lose        <= lose_nx;
    end
  end

endmodule

// File: tb/tb_mastermind_game_sequencer.sv
// Bench for mastermind_game_sequencer: a behavioural game model is updated on
// every rising edge and compared with the DUT on every falling edge. Directed
// scenarios with literal expectations are followed by a randomized run.
module tb_mastermind_game_sequencer;
  localparam int DIGITS = 4, IDX_W = 2, PEG_W = 3, MAXG = 8, CNT_W = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0, load_btn = 1'b0, new_game = 1'b0, score_done = 1'b0;
  logic [PEG_W-1:0] red_in = '0, white_in = '0;
  logic [IDX_W-1:0] sel_digit;
  logic code_we, guess_we, score_start, win, lose;
  logic [PEG_W-1:0] red_out, white_out;
  logic [CNT_W-1:0] guess_cnt;
  logic [2:0] state_dbg;

  mastermind_game_sequencer #(.DIGITS(DIGITS), .IDX_W(IDX_W), .PEG_W(PEG_W),
    .MAX_GUESSES(MAXG), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .load_btn(load_btn), .new_game(new_game),
    .sel_digit(sel_digit), .code_we(code_we), .guess_we(guess_we),
    .score_start(score_start), .score_done(score_done), .red_in(red_in),
    .white_in(white_in), .red_out(red_out), .white_out(white_out),
    .guess_cnt(guess_cnt), .win(win), .lose(lose), .state_dbg(state_dbg));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 code entry, 1 guess entry, 2 score, 3 waiting for scorer, 4 won, 5 lost
  int m_phase = 0, m_digits = 0, m_cnt = 0, m_red = 0, m_white = 0, m_sel = 0;
  bit m_key_was = 1, m_cw = 0, m_gw = 0, m_rst = 0, m_ok = 0;

  always @(posedge clk) begin
    bit pressed;
    pressed = load_btn && !m_key_was;
    m_cw = 0; m_gw = 0;
    m_ok = 1;
    if (!resetn) begin
      m_phase = 0; m_digits = 0; m_cnt = 0; m_red = 0; m_white = 0; m_sel = 0;
      m_key_was = 1; m_rst = 1;
    end else begin
      m_key_was = load_btn; m_rst = 0;
      if (new_game) begin
        m_phase = 0; m_digits = 0; m_cnt = 0; m_red = 0; m_white = 0;
      end else if ((m_phase == 0 || m_phase == 1) && pressed) begin
        if (m_phase == 0) m_cw = 1; else m_gw = 1;
        m_sel = m_digits;
        m_digits++;
        if (m_digits == DIGITS) begin m_digits = 0; m_phase++; end
      end else if (m_phase == 2) begin
        m_phase = 3;
      end else if (m_phase == 3 && score_done) begin
        m_red = red_in; m_white = white_in; m_cnt++;
        if (red_in == DIGITS) m_phase = 4;
        else if (m_cnt == MAXG) m_phase = 5;
        else m_phase = 1;
      end
    end
  end

  // ---------------- compare process + strobe monitor ----------------
  int n_cw = 0, n_gw = 0, n_ss = 0;
  logic [7:0] sel_hist = '0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("state_dbg", state_dbg, m_phase);
      chk("code_we", code_we, m_cw);
      chk("guess_we", guess_we, m_gw);
      chk("score_start", score_start, m_phase == 2);
      chk("red_out", red_out, m_red);
      chk("white_out", white_out, m_white);
      chk("guess_cnt", guess_cnt, m_cnt);
      chk("win", win, m_phase == 4);
      chk("lose", lose, m_phase == 5);
      if (m_cw || m_gw || m_rst) chk("sel_digit", sel_digit, m_sel);
    end
    if (code_we) n_cw++;
    if (guess_we) n_gw++;
    if (score_start) n_ss++;
    if (code_we || guess_we) sel_hist = {sel_hist[5:0], sel_digit};
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk); load_btn = 1'b1;
    @(negedge clk); load_btn = 1'b0;
    cyc(3);
  endtask

  task automatic presses(input int n);
    for (int i = 0; i < n; i++) press();
  endtask

  task automatic score(input int r, input int w);
    @(negedge clk); score_done = 1'b1; red_in = PEG_W'(r); white_in = PEG_W'(w);
    @(negedge clk); score_done = 1'b0; red_in = '0; white_in = '0;
    cyc(1);
  endtask

  task automatic restart();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
  endtask

  int b_cw, b_gw, b_ss;

  initial begin
    // reset with the key held: it must not count as a press afterwards
    load_btn = 1'b1;
    cyc(3);
    resetn = 1'b1;
    cyc(3);
    chk("reset state", state_dbg, 0);
    chk("reset held key no strobe", n_cw, 0);
    load_btn = 1'b0;
    cyc(2);

    // T1 code entry
    presses(4);
    chk("T1 code_we count", n_cw, 4);
    chk("T1 sel order", sel_hist, 8'b00_01_10_11);
    chk("T1 state", state_dbg, 1);

    // T2 held key
    b_gw = n_gw;
    @(negedge clk); load_btn = 1'b1;
    cyc(20);
    load_btn = 1'b0;
    cyc(2);
    chk("T2 one guess_we", n_gw - b_gw, 1);
    chk("T2 sel", sel_hist[1:0], 0);

    // T3 scoring: three more presses complete the guess (idx was 1)
    b_ss = n_ss;
    presses(3);
    chk("T3 sel after held", sel_hist, 8'b00_01_10_11);
    chk("T3 wait state", state_dbg, 3);
    cyc(10);
    chk("T3 one score_start", n_ss - b_ss, 1);
    score(2, 1);
    chk("T3 red", red_out, 2);
    chk("T3 white", white_out, 1);
    chk("T3 cnt", guess_cnt, 1);
    chk("T3 state", state_dbg, 1);

    // T4 win
    presses(4);
    score(4, 0);
    chk("T4 win", win, 1);
    chk("T4 state", state_dbg, 4);
    b_cw = n_cw; b_gw = n_gw;
    presses(2);
    chk("T4 no strobes", (n_cw - b_cw) + (n_gw - b_gw), 0);

    // T5 loss
    restart();
    presses(4);
    for (int g = 0; g < MAXG; g++) begin
      presses(4);
      score(1, 2);
    end
    chk("T5 lose", lose, 1);
    chk("T5 cnt", guess_cnt, 8);
    chk("T5 state", state_dbg, 5);

    // T6 new_game beats a press
    restart();
    presses(4);
    presses(4);
    score(3, 1);
    chk("T6 red before", red_out, 3);
    press();
    b_gw = n_gw;
    @(negedge clk); load_btn = 1'b1; new_game = 1'b1;
    @(negedge clk); load_btn = 1'b0; new_game = 1'b0;
    cyc(2);
    chk("T6 no guess_we", n_gw - b_gw, 0);
    chk("T6 state", state_dbg, 0);
    chk("T6 cnt", guess_cnt, 0);
    chk("T6 red", red_out, 0);
    // reset while in SCORE_WAIT
    presses(4);
    presses(4);
    chk("T6 in wait", state_dbg, 3);
    @(negedge clk); resetn = 1'b0; new_game = 1'b1;
    @(negedge clk); resetn = 1'b1; new_game = 1'b0;
    chk("T6 reset outs", {state_dbg, red_out, white_out, guess_cnt, win, lose,
                          code_we, guess_we, score_start}, 0);

    // randomized run
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) load_btn = ~load_btn;
      score_done = ($urandom_range(0, 5) == 0);
      red_in = PEG_W'($urandom_range(0, 4));
      white_in = PEG_W'($urandom_range(0, 4));
      new_game = ($urandom_range(0, 299) == 0);
      resetn = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk); resetn = 1'b1; new_game = 1'b0; score_done = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
